// File: rtl/matrix_10x10_mem.sv
// Purpose: 10x10 operand/result matrix store, one element written or read per access by (row, col).
// Latency: writes land on the next rising clk; reads are combinational (0 cycles).
// Backpressure: none; every access is accepted. Optional MATRIX_CLEAR_EN adds a synchronous whole-matrix clear.
module matrix_10x10_mem #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef MATRIX_CLEAR_EN
    input  logic                  en_ClearMat,
`endif
    input  logic                  en_ReadMat,
    input  logic                  en_WriteMat,
    input  logic [3:0]            rowAddr,
    input  logic [3:0]            colAddr,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData
);

    logic [DATA_WIDTH-1:0] mem [0:9][0:9];
    logic                  addr_ok;

    // Indices 10..15 are rejected outright so they never alias onto a real entry.
    assign addr_ok = (rowAddr <= 4'd9) && (colAddr <= 4'd9);

    // Storage update: async clear on rst, optional sync clear (wins over write), else single-entry write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 10; r++) begin
                for (int c = 0; c < 10; c++) begin
                    mem[r][c] <= '0;
                end
            end
        end
`ifdef MATRIX_CLEAR_EN
        else if (en_ClearMat) begin
            for (int r = 0; r < 10; r++) begin
                for (int c = 0; c < 10; c++) begin
                    mem[r][c] <= '0;
                end
            end
        end
`endif
        else if (en_WriteMat && addr_ok) begin
            mem[rowAddr][colAddr] <= writeData;
        end
    end

    // Combinational read straight from storage; zero when disabled or out of range (no write bypass).
    always_comb begin
        readData = '0;
        if (en_ReadMat && addr_ok) begin
            readData = mem[rowAddr][colAddr];
        end
    end

endmodule

// File: tb/tb_matrix_10x10_mem.sv
// Purpose: self-checking bench for matrix_10x10_mem with a queue-based scoreboard.
// Latency: expects writes visible right after the clk edge, reads with zero latency.
// Backpressure: n/a; stimulus drives at posedge+1, monitor samples readData at negedge.
module tb_matrix_10x10_mem;

    logic       clk;
    logic       rst;
`ifdef MATRIX_CLEAR_EN
    logic       en_ClearMat;
`endif
    logic       en_ReadMat;
    logic       en_WriteMat;
    logic [3:0] rowAddr;
    logic [3:0] colAddr;
    logic [7:0] writeData;
    logic [7:0] readData;

    typedef struct {
        logic [7:0] val;
        logic [3:0] r;
        logic [3:0] c;
    } exp_t;

    exp_t       exp_q[$];
    logic       chk_vld;
    int         checks;
    int         failures;
    logic [7:0] model [0:9][0:9];

    matrix_10x10_mem #(.DATA_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef MATRIX_CLEAR_EN
        .en_ClearMat (en_ClearMat),
`endif
        .en_ReadMat  (en_ReadMat),
        .en_WriteMat (en_WriteMat),
        .rowAddr     (rowAddr),
        .colAddr     (colAddr),
        .writeData   (writeData),
        .readData    (readData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: whenever the stimulus marks readData as meaningful, pop and compare.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_vld) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard_underflow got=%0d expected an entry", readData);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (readData !== e.val) begin
                        failures++;
                        $display("FAIL read[%0d,%0d] got=%0d expected=%0d", e.r, e.c, readData, e.val);
                    end
                end
            end
        end
    end

    function automatic logic [7:0] model_rd(input logic [3:0] r, input logic [3:0] c);
        if (r <= 4'd9 && c <= 4'd9) return model[r][c];
        return 8'd0;
    endfunction

    task automatic push_exp(input logic [7:0] v, input logic [3:0] r, input logic [3:0] c);
        exp_t e;
        e.val = v;
        e.r = r;
        e.c = c;
        exp_q.push_back(e);
        chk_vld = 1'b1;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
        chk_vld = 1'b0;
    endtask

    task automatic idle_all();
        en_ReadMat  = 1'b0;
        en_WriteMat = 1'b0;
`ifdef MATRIX_CLEAR_EN
        en_ClearMat = 1'b0;
`endif
    endtask

    // Write cycle with reads disabled: readData must sit at 0 meanwhile.
    task automatic do_write(input logic [3:0] r, input logic [3:0] c, input logic [7:0] d);
        idle_all();
        en_WriteMat = 1'b1;
        rowAddr = r;
        colAddr = c;
        writeData = d;
        push_exp(8'd0, r, c);
        next_cyc();
        if (r <= 4'd9 && c <= 4'd9 && !rst) model[r][c] = d;
        en_WriteMat = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] r, input logic [3:0] c, input logic [7:0] exp_v);
        idle_all();
        en_ReadMat = 1'b1;
        rowAddr = r;
        colAddr = c;
        push_exp(exp_v, r, c);
        next_cyc();
        en_ReadMat = 1'b0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 10; j++)
                model[i][j] = 8'd0;
    endtask

    task automatic read_all();
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 10; j++)
                do_read(4'(i), 4'(j), model_rd(4'(i), 4'(j)));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        chk_vld = 1'b0;
        rst = 1'b1;
        idle_all();
        rowAddr = 4'd0;
        colAddr = 4'd0;
        writeData = 8'd0;
        clear_model();

        // Reads during reset return 0.
        repeat (2) next_cyc();
        do_read(4'd3, 4'd4, 8'd0);
        rst = 1'b0;

        // Reset state: all zeros.
        read_all();

        // Fill pattern (i*10+j)*2 and read back.
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 10; j++)
                do_write(4'(i), 4'(j), 8'(((i * 10) + j) * 2));
        read_all();
        do_read(4'd9, 4'd9, 8'd198);

        // Single overwrite; neighbour untouched.
        do_write(4'd3, 4'd3, 8'd100);
        do_read(4'd3, 4'd3, 8'd100);
        do_read(4'd4, 4'd5, 8'd90);

        // Out-of-range writes are ignored and reads give 0.
        do_write(4'd10, 4'd2, 8'hAA);
        do_write(4'd2, 4'd15, 8'h55);
        do_read(4'd0, 4'd2, 8'd4);
        do_read(4'd2, 4'd5, 8'd50);
        do_read(4'd10, 4'd2, 8'd0);
        do_read(4'd2, 4'd15, 8'd0);
        do_read(4'd15, 4'd15, 8'd0);

        // Simultaneous read+write: old value before edge, new value after.
        idle_all();
        en_ReadMat = 1'b1;
        en_WriteMat = 1'b1;
        rowAddr = 4'd5;
        colAddr = 4'd5;
        writeData = 8'h33;
        push_exp(8'd110, 4'd5, 4'd5);
        next_cyc();
        model[5][5] = 8'h33;
        do_read(4'd5, 4'd5, 8'h33);

        // Both enables low at a populated address: output gated to 0.
        idle_all();
        rowAddr = 4'd9;
        colAddr = 4'd9;
        push_exp(8'd0, 4'd9, 4'd9);
        next_cyc();

        // Async reset between edges: readData drops before the next edge.
        do_read(4'd9, 4'd9, 8'd198);
        idle_all();
        en_ReadMat = 1'b1;
        rowAddr = 4'd9;
        colAddr = 4'd9;
        #1;
        rst = 1'b1;
        clear_model();
        push_exp(8'd0, 4'd9, 4'd9);
        next_cyc();
        // Write attempted while reset is held must be blocked.
        do_write(4'd0, 4'd0, 8'h11);
        rst = 1'b0;
        read_all();

        // First write after reset release lands at the next edge.
        do_write(4'd1, 4'd2, 8'h77);
        do_read(4'd1, 4'd2, 8'h77);

`ifdef MATRIX_CLEAR_EN
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 10; j++)
                do_write(4'(i), 4'(j), 8'(i + j + 1));
        idle_all();
        en_ClearMat = 1'b1;
        en_WriteMat = 1'b1;
        en_ReadMat = 1'b1;
        rowAddr = 4'd1;
        colAddr = 4'd1;
        writeData = 8'd7;
        push_exp(8'd3, 4'd1, 4'd1);
        next_cyc();
        en_ClearMat = 1'b0;
        clear_model();
        read_all();
`endif

        idle_all();
        next_cyc();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
